// File: rtl/fetch_pc_unit.sv
`default_nettype none
//==============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch and next-PC stage. Holds the PC, fetches one
//               32-bit word per instruction over a req/ready handshake, presents
//               it to decode and selects the next PC when the datapath retires
//               the instruction.
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  // decode interface
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  // control from decoder / datapath, sampled on retire
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  input  logic        j,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] rs_data,
  // status
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        err_misalign,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // The PC is stored as a word address so that pc[1:0] can never be non-zero;
  // the two low bits of RESET_PC are deliberately dropped.
  localparam logic [29:0] c_reset_pc_w = RESET_PC[31:2];

  state_t      r_state;
  logic        r_run;        // first edge after reset release seen
  logic [29:0] r_pc_w;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_req;
  logic        r_err;
  logic [31:0] r_count;

  logic [29:0] w_pc_plus4_w;
  logic [29:0] w_br_off_w;
  logic        w_br_taken;
  logic [29:0] w_next_pc_w;
  logic        w_retire;
  logic        w_jr_misalign;

  // Sequential PC, branch offset and the prioritised next-PC selection.
  always_comb begin
    w_pc_plus4_w  = r_pc_w + 30'd1;
    w_br_off_w    = {{14{r_instr[15]}}, r_instr[15:0]};
    w_br_taken    = branch & (bne ? ~zero : zero);
    w_retire      = (r_state == S_HOLD) & instr_accept;
    w_jr_misalign = jr & (rs_data[1:0] != 2'b00);
    w_next_pc_w   = w_pc_plus4_w;
    if (jr) begin
      w_next_pc_w = rs_data[31:2];
    end else if (j | jal) begin
      w_next_pc_w = {w_pc_plus4_w[29:26], r_instr[25:0]};
    end else if (w_br_taken) begin
      w_next_pc_w = w_pc_plus4_w + w_br_off_w;
    end
  end

  // Fetch/hold state machine with all architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_pc_w  <= c_reset_pc_w;
      r_instr <= 32'h0000_0000;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
      r_count <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The release edge only arms r_run; IDLE then lasts one full cycle.
          r_run <= 1'b1;
          if (r_run) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_retire) begin
            r_pc_w  <= w_next_pc_w;
            r_valid <= 1'b0;
            r_count <= r_count + 32'd1;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
            if (w_jr_misalign) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc            = {r_pc_w, 2'b00};
  assign link_addr     = {w_pc_plus4_w, 2'b00};
  assign imem_req      = r_req;
  assign imem_addr     = {r_pc_w, 2'b00};
  assign instr         = r_instr;
  assign instr_valid   = r_valid;
  assign err_misalign  = r_err;
  assign retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit with directed scenarios
//               and randomized instruction streams against a reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch, bne, zero, j, jal, jr;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        err_misalign;
  logic [31:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_err;
  logic [31:0] m_instr;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_accept(instr_accept),
    .branch(branch), .bne(bne), .zero(zero), .j(j), .jal(jal), .jr(jr),
    .rs_data(rs_data), .pc(pc), .link_addr(link_addr),
    .err_misalign(err_misalign), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // next PC computed from the architectural rules with plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] iw,
                                             input bit br, input bit ne, input bit zf,
                                             input bit jj, input bit jl, input bit jrr,
                                             input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jrr) return rs - (rs % 4);
    if (jj || jl) return (seq / 32'h1000_0000) * 32'h1000_0000 + (iw % 32'h0400_0000) * 4;
    if (br && ((ne && !zf) || (!ne && zf))) begin
      off = $signed(iw[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic clear_inputs();
    imem_ready = 0; imem_rdata = 0; instr_accept = 0;
    branch = 0; bne = 0; zero = 0; j = 0; jal = 0; jr = 0; rs_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_pc = 0; m_count = 0; m_err = 0; m_instr = 0;
  endtask

  // Wait (bounded) for a request, hold ready low for 'delay' cycles, then return word w.
  task automatic fetch_word(input logic [31:0] w, input int delay, output bit stable);
    bit          seen;
    logic [31:0] a;
    seen = 0; stable = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) seen = 1;
    end
    if (!seen) begin
      n_fail++;
      $display("FAIL fetch_timeout: imem_req=%b required 1 within 10 cycles", imem_req);
      return;
    end
    a = imem_addr;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (imem_addr !== a || imem_req !== 1'b1) stable = 0;
    end
    imem_rdata = w;
    imem_ready = 1;
    @(posedge clk); #1;
    imem_ready = 0;
    imem_rdata = $urandom;
    m_instr = w;
  endtask

  // Retire the held instruction with the given controls; advances the model.
  task automatic do_retire(input bit br, input bit ne, input bit zf, input bit jj,
                           input bit jl, input bit jrr, input logic [31:0] rs,
                           output logic [31:0] link_seen);
    @(negedge clk);
    link_seen = link_addr;
    branch = br; bne = ne; zero = zf; j = jj; jal = jl; jr = jrr; rs_data = rs;
    instr_accept = 1;
    m_pc = model_next(m_pc, m_instr, br, ne, zf, jj, jl, jrr, rs);
    m_count = m_count + 1;
    if (jrr && (rs % 4) != 0) m_err = 1;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic goto_pc(input logic [31:0] target);
    bit          st;
    logic [31:0] lk;
    fetch_word($urandom, 0, st);
    do_retire(0, 0, 0, 0, 0, 1, target, lk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr: got %h/%b want 0/0", instr, instr_valid); end
    n_checks++; if (imem_req !== 1'b0 || err_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_req_err: got %b/%b want 0/0", imem_req, err_misalign); end
    n_checks++; if (retired_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    n_checks++; if (link_addr !== 32'h4) begin n_fail++; $display("FAIL reset_link: got %h want 4", link_addr); end
    rst_n = 1;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL start_req_early: got %b want 0", imem_req); end
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL start_req: got %b addr %h want 1 addr 0", imem_req, imem_addr); end
    imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ready = 0;
    n_checks++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL start_fetch: got %b %h want 1 deadbeef", instr_valid, instr); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem_req); end
  endtask

  task automatic test_sequential();
    int          delays[4] = '{0, 1, 3, 0};
    bit          st;
    logic [31:0] w, lk;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      fetch_word(w, delays[i], st);
      n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL seq_addr_stable[%0d]: got %b want 1", i, st); end
      n_checks++; if (pc !== 32'(i * 4) || instr !== w || instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fetch[%0d]: pc %h instr %h v %b want pc %h instr %h v 1", i, pc, instr, instr_valid, 32'(i * 4), w); end
      do_retire(0, 0, 0, 0, 0, 0, 0, lk);
    end
    n_checks++; if (pc !== 32'h10 || retired_count !== 32'd4) begin n_fail++; $display("FAIL seq_end: pc %h count %0d want 10 4", pc, retired_count); end
  endtask

  task automatic test_branch();
    bit          st;
    logic [31:0] lk;
    // pc is 0x10 on entry
    fetch_word(32'h1000_FFFE, 0, st);
    do_retire(1, 0, 1, 0, 0, 0, 0, lk);
    n_checks++; if (pc !== 32'h0C || pc !== m_pc) begin n_fail++; $display("FAIL br_beq_taken: got %h want 0c", pc); end
    goto_pc(32'h10);
    fetch_word(32'h1000_FFFE, 1, st);
    do_retire(1, 0, 0, 0, 0, 0, 0, lk);
    n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL br_beq_not_taken: got %h want 14", pc); end
    goto_pc(32'h10);
    fetch_word(32'h1400_0003, 0, st);
    do_retire(1, 1, 0, 0, 0, 0, 0, lk);
    n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL br_bne_taken: got %h want 20", pc); end
    n_checks++; if (err_misalign !== 1'b0) begin n_fail++; $display("FAIL br_err: got %b want 0", err_misalign); end
  endtask

  task automatic test_jumps();
    bit          st;
    logic [31:0] lk;
    goto_pc(32'h1000_0004);
    fetch_word(32'h0800_0100, 0, st);
    do_retire(0, 0, 0, 1, 0, 0, 0, lk);
    n_checks++; if (pc !== 32'h1000_0400) begin n_fail++; $display("FAIL j_target: got %h want 10000400", pc); end
    goto_pc(32'h1000_0004);
    fetch_word(32'h0C00_0100, 2, st);
    do_retire(1, 0, 1, 0, 1, 0, 0, lk);
    n_checks++; if (pc !== 32'h1000_0400) begin n_fail++; $display("FAIL jal_target: got %h want 10000400", pc); end
    n_checks++; if (lk !== 32'h1000_0008) begin n_fail++; $display("FAIL jal_link: got %h want 10000008", lk); end
    fetch_word(32'h0800_0100, 0, st);
    do_retire(0, 0, 0, 1, 0, 1, 32'h0000_0203, lk);
    n_checks++; if (pc !== 32'h200 || err_misalign !== 1'b1) begin n_fail++; $display("FAIL jr_misalign: pc %h err %b want 200 1", pc, err_misalign); end
    fetch_word($urandom, 0, st);
    do_retire(0, 0, 0, 0, 0, 0, 0, lk);
    n_checks++; if (err_misalign !== 1'b1 || pc !== 32'h204) begin n_fail++; $display("FAIL err_sticky: err %b pc %h want 1 204", err_misalign, pc); end
  endtask

  task automatic test_wrap_ignore();
    bit          st;
    logic [31:0] w, lk, cnt;
    goto_pc(32'hFFFF_FFFC);
    fetch_word($urandom & 32'h03FF_0000, 0, st);
    do_retire(0, 0, 0, 0, 0, 0, 0, lk);
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h want 0", pc); end
    cnt = m_count;
    // spurious accept while fetching
    @(negedge clk);
    instr_accept = 1; jr = 1; rs_data = 32'h40;
    @(posedge clk); #1;
    clear_inputs();
    n_checks++; if (pc !== 32'h0 || retired_count !== cnt || imem_req !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL ignore_accept: pc %h cnt %0d req %b v %b want 0 %0d 1 0", pc, retired_count, imem_req, instr_valid, cnt); end
    w = $urandom;
    fetch_word(w, 0, st);
    // spurious ready while holding
    @(negedge clk);
    imem_ready = 1; imem_rdata = ~w;
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    n_checks++; if (instr !== w || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL ignore_ready: instr %h v %b req %b pc %h want %h 1 0 0", instr, instr_valid, imem_req, pc, w); end
    do_retire(0, 0, 0, 0, 0, 0, 0, lk);
  endtask

  task automatic test_random();
    bit          st, br, ne, zf, jj, jl, jrr;
    logic [31:0] w, rs, lk, exp_link;
    int          errs;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      w   = $urandom;
      rs  = $urandom;
      br  = ($urandom_range(0, 1) == 1);
      ne  = ($urandom_range(0, 1) == 1);
      zf  = ($urandom_range(0, 1) == 1);
      jj  = ($urandom_range(0, 4) == 0);
      jl  = ($urandom_range(0, 4) == 0);
      jrr = ($urandom_range(0, 4) == 0);
      fetch_word(w, $urandom_range(0, 2), st);
      n_checks++;
      if (instr !== w || instr_valid !== 1'b1 || pc !== m_pc || !st) begin
        n_fail++;
        $display("FAIL rand_fetch[%0d]: instr %h v %b pc %h stable %b want %h 1 %h 1", i, instr, instr_valid, pc, st, w, m_pc);
      end
      exp_link = m_pc + 4;
      do_retire(br, ne, zf, jj, jl, jrr, rs, lk);
      n_checks++;
      if (pc !== m_pc || retired_count !== m_count || err_misalign !== m_err || lk !== exp_link) begin
        n_fail++;
        $display("FAIL rand_retire[%0d]: pc %h cnt %0d err %b link %h want %h %0d %b %h", i, pc, retired_count, err_misalign, lk, m_pc, m_count, m_err, exp_link);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reset_wait: imem_req=%b want 1", imem_req); end
    @(negedge clk);
    imem_ready = 1; imem_rdata = 32'hCAFE_F00D;
    rst_n = 0;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_reset_async_req: got %b want 0", imem_req); end
    @(posedge clk); #1;
    n_checks++; if (instr_valid !== 1'b0 || pc !== 32'h0 || retired_count !== 32'h0 || err_misalign !== 1'b0 || instr !== 32'h0) begin n_fail++; $display("FAIL mid_reset_state: v %b pc %h cnt %0d err %b instr %h want 0", instr_valid, pc, retired_count, err_misalign, instr); end
    imem_ready = 0;
    @(negedge clk);
    rst_n = 1;
    m_pc = 0; m_count = 0; m_err = 0;
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL restart_idle: req %b want 0", imem_req); end
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL restart_fetch: req %b addr %h v %b want 1 0 0", imem_req, imem_addr, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jumps();
    test_wrap_ignore();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
